// File: rtl/video_cfg_sequencer.sv
// Configuration sequencer for the daisy-chain cores' bypass registers.
// Synchronizes/debounces board inputs, tracks pending per-core updates and
// issues one Avalon-MM write at a time with a waitrequest handshake.
module video_cfg_sequencer #(
  parameter int unsigned NUM_CORE        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NUM_CORE-1:0]      bypass_req,
  input  logic                     key_n,
  input  logic                     auto_mode,
  output logic [NUM_CORE-1:0]      avs_address,
  output logic [NUM_CORE-1:0]      avs_write,
  output logic [32*NUM_CORE-1:0]   avs_writedata,
  input  logic [NUM_CORE-1:0]      avs_waitrequest,
  output logic [NUM_CORE-1:0]      cfg_shadow,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CORE-1:0]      err
);

  localparam int unsigned CW  = (NUM_CORE > 1)        ? $clog2(NUM_CORE)        : 1;
  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TW  = (TIMEOUT_CYCLES > 1)  ? $clog2(TIMEOUT_CYCLES)  : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WARMUP,
    S_IDLE,
    S_WRITE,
    S_NEXT
  } state_e;

  // synchronizers
  logic [NUM_CORE-1:0] bypass_m_q, bypass_s_q;
  logic                key_m_q, key_s_q;
  logic                auto_m_q, auto_s_q;

  // debounce
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           key_prev_q;
  logic           key_db_q, key_db_d;
  logic           press;

  // sequencer
  state_e              state_q, state_d;
  logic [1:0]          warm_q, warm_d;
  logic [CW-1:0]       cur_q, cur_d;
  logic                wdata_q, wdata_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                ok_q, ok_d;
  logic                after_next_q;
  logic [NUM_CORE-1:0] pend_q, pend_d, pend_set, pend_clr;
  logic [NUM_CORE-1:0] shadow_q, shadow_d;
  logic [NUM_CORE-1:0] err_q, err_d;
  logic [CW-1:0]       low_idx;
  logic                low_found;

  // two-flop synchronizers; key idles high so it resets high
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bypass_m_q <= '0;
      bypass_s_q <= '0;
      key_m_q    <= 1'b1;
      key_s_q    <= 1'b1;
      auto_m_q   <= 1'b0;
      auto_s_q   <= 1'b0;
    end else begin
      bypass_m_q <= bypass_req;
      bypass_s_q <= bypass_m_q;
      key_m_q    <= key_n;
      key_s_q    <= key_m_q;
      auto_m_q   <= auto_mode;
      auto_s_q   <= auto_m_q;
    end
  end

  // debounce: restart on any synchronized change, accept once the count saturates
  always_comb begin
    db_cnt_d = db_cnt_q;
    key_db_d = key_db_q;
    press    = 1'b0;
    if (key_s_q != key_prev_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      key_db_d = key_s_q;
      press    = key_db_q & ~key_s_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // lowest pending core index
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CORE; i++) begin
      if (pend_q[i] && !low_found) begin
        low_idx   = CW'(i);
        low_found = 1'b1;
      end
    end
  end

  // pending set/clear; the core being written is masked from the mismatch compare
  always_comb begin
    pend_set = '0;
    if (press) pend_set = '1;
    if (auto_s_q) begin
      for (int unsigned i = 0; i < NUM_CORE; i++) begin
        if ((bypass_s_q[i] != shadow_q[i]) &&
            !(((state_q == S_WRITE) || (state_q == S_NEXT)) && (cur_q == CW'(i))))
          pend_set[i] = 1'b1;
      end
    end
    pend_d = (pend_q & ~pend_clr) | pend_set;
  end

  // next-state and write-strobe logic
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    cur_d     = cur_q;
    wdata_d   = wdata_q;
    tmo_d     = tmo_q;
    ok_d      = ok_q;
    shadow_d  = shadow_q;
    err_d     = err_q;
    pend_clr  = '0;
    avs_write = '0;
    case (state_q)
      S_WARMUP: begin
        if (warm_q == 2'd2) state_d = S_IDLE;
        else                warm_d  = warm_q + 2'd1;
      end
      S_IDLE: begin
        if (pend_q != '0) begin
          cur_d   = low_idx;
          wdata_d = bypass_s_q[low_idx];
          tmo_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        avs_write[cur_q] = 1'b1;
        if (!avs_waitrequest[cur_q]) begin
          ok_d    = 1'b1;
          state_d = S_NEXT;
        end else if (tmo_q == TMO_LAST) begin
          ok_d    = 1'b0;
          state_d = S_NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_NEXT: begin
        pend_clr[cur_q] = 1'b1;
        if (ok_q) begin
          shadow_d[cur_q] = wdata_q;
          err_d[cur_q]    = 1'b0;
        end else begin
          err_d[cur_q] = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_WARMUP;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt_q     <= '0;
      key_prev_q   <= 1'b1;
      key_db_q     <= 1'b1;
      state_q      <= S_WARMUP;
      warm_q       <= '0;
      cur_q        <= '0;
      wdata_q      <= 1'b0;
      tmo_q        <= '0;
      ok_q         <= 1'b0;
      after_next_q <= 1'b0;
      pend_q       <= '1;
      shadow_q     <= '0;
      err_q        <= '0;
    end else begin
      db_cnt_q     <= db_cnt_d;
      key_prev_q   <= key_s_q;
      key_db_q     <= key_db_d;
      state_q      <= state_d;
      warm_q       <= warm_d;
      cur_q        <= cur_d;
      wdata_q      <= wdata_d;
      tmo_q        <= tmo_d;
      ok_q         <= ok_d;
      after_next_q <= (state_q == S_NEXT);
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      err_q        <= err_d;
    end
  end

  // write data replicated into every core slice; only the strobed core samples it
  always_comb begin
    avs_writedata = '0;
    for (int unsigned i = 0; i < NUM_CORE; i++)
      avs_writedata[32*i +: 32] = {31'b0, wdata_q};
  end

  assign avs_address = '0;
  assign cfg_shadow  = shadow_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE) || (pend_q != '0);
  assign done        = (state_q == S_IDLE) && after_next_q && (pend_q == '0);

endmodule

// File: tb/tb_video_cfg_sequencer.sv
// Self-checking bench for video_cfg_sequencer: randomized switch/key/waitrequest
// stimulus compared against a transaction-level schedule model.
module tb_video_cfg_sequencer;

  localparam int DEB  = 8;
  localparam int TMO  = 16;
  localparam int MAXC = 256;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [1:0]  bypass_req = '0;
  logic        key_n = 1'b1;
  logic        auto_mode = 1'b0;
  logic [1:0]  avs_address;
  logic [1:0]  avs_write;
  logic [63:0] avs_writedata;
  logic [1:0]  avs_waitrequest = '0;
  logic [1:0]  cfg_shadow;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int checks = 0;
  int failures = 0;

  // model state: current switch value, expected shadow and error flags
  logic [1:0] bp;
  logic [1:0] m_shadow;
  logic [1:0] m_err;

  always #5 sys_clk = ~sys_clk;

  video_cfg_sequencer #(
    .NUM_CORE       (2),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .bypass_req     (bypass_req),
    .key_n          (key_n),
    .auto_mode      (auto_mode),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_waitrequest(avs_waitrequest),
    .cfg_shadow     (cfg_shadow),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at the negedge of cycle 0 (trigger just applied). Each pending core,
  // lowest index first, gets a write starting at 'start'; it lasts wait+1 cycles,
  // or TMO cycles if waitrequest outlasts the timeout. Two cycles (NEXT, IDLE)
  // separate writes; done pulses one cycle after the last NEXT.
  task automatic run_seq(input logic [1:0] pmask, input int w0, input int w1,
                         input int start, input int key_hold, input int extra);
    logic [1:0] e_wr [MAXC];
    logic [1:0] e_wq [MAXC];
    int w [2];
    int s, h, done_c, last, idx;
    for (int c = 0; c < MAXC; c++) begin
      e_wr[c] = '0;
      e_wq[c] = '0;
    end
    w[0] = w0;
    w[1] = w1;
    s = start;
    done_c = -1;
    for (int i = 0; i < 2; i++) begin
      if (pmask[i]) begin
        h = (w[i] >= TMO) ? TMO : w[i] + 1;
        for (int c = s; c < s + h; c++) begin
          e_wr[c][i] = 1'b1;
          e_wq[c][i] = ((c - s) < w[i]);
        end
        if (w[i] < TMO) begin
          m_shadow[i] = bp[i];
          m_err[i]    = 1'b0;
        end else begin
          m_err[i] = 1'b1;
        end
        s = s + h + 2;
      end
    end
    if (pmask != 2'b00) begin
      done_c = s - 1;
      last   = done_c + 3;
    end else begin
      last = extra;
    end
    for (int k = 1; k <= last; k++) begin
      @(posedge sys_clk);
      #1;
      avs_waitrequest = e_wq[k];
      key_n = (k < key_hold) ? 1'b0 : 1'b1;
      @(negedge sys_clk);
      chk("avs_write", 64'(avs_write), 64'(e_wr[k]));
      chk("done", 64'(done), 64'(k == done_c));
      if (e_wr[k] != 2'b00) begin
        idx = e_wr[k][1] ? 1 : 0;
        chk("writedata", 64'(avs_writedata[32*idx +: 32]), 64'({31'b0, bp[idx]}));
        chk("address", 64'(avs_address), 64'(0));
      end
      if (pmask != 2'b00 && k == start) chk("busy_start", 64'(busy), 64'(1));
      if (k == done_c) chk("busy_done", 64'(busy), 64'(0));
    end
    avs_waitrequest = '0;
    chk("cfg_shadow", 64'(cfg_shadow), 64'(m_shadow));
    chk("err", 64'(err), 64'(m_err));
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      chk("idle_write", 64'(avs_write), 64'(0));
      chk("idle_done", 64'(done), 64'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int pw0 [4];
    int pw1 [4];
    int w0, w1, g;
    logic [1:0] flip;
    pw0 = '{0, 0, 100, 15};
    pw1 = '{0, 5, 0, 16};

    // power-on reset with 2'b10 on the switches
    bp = 2'b10;
    bypass_req = bp;
    #2 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_write", 64'(avs_write), 64'(0));
    chk("rst_shadow", 64'(cfg_shadow), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1));
    sys_rst_n = 1'b1;
    m_shadow = '0;
    m_err = '0;
    run_seq(2'b11, 0, 0, 4, 0, 0);

    // key glitches shorter than the debounce window, switches changing in manual mode
    for (int n = 0; n < 3; n++) begin
      g = $urandom_range(1, DEB - 1);
      bp = 2'($urandom_range(0, 3));
      bypass_req = bp;
      key_n = 1'b0;
      run_seq(2'b00, 0, 0, 0, g, 3 * DEB + 10);
    end

    // key presses: fixed waitrequest cases (hold, timeout, timeout boundary), then random
    for (int n = 0; n < 9; n++) begin
      if (n < 4) begin
        w0 = pw0[n];
        w1 = pw1[n];
      end else if (n < 8) begin
        w0 = $urandom_range(0, 20);
        w1 = $urandom_range(0, 20);
      end else begin
        w0 = 0;
        w1 = 0;
      end
      bp = 2'($urandom_range(0, 3));
      bypass_req = bp;
      key_n = 1'b0;
      run_seq(2'b11, w0, w1, DEB + 4, DEB + 6, 0);
      idle_check(2 * DEB + 12);
    end

    // auto mode: enabling with matched switches writes nothing, then random flips
    auto_mode = 1'b1;
    idle_check(8);
    for (int n = 0; n < 8; n++) begin
      flip = (n == 0) ? 2'b01 : 2'($urandom_range(1, 3));
      w0 = $urandom_range(0, 8);
      w1 = $urandom_range(0, 8);
      bp = bp ^ flip;
      bypass_req = bp;
      run_seq(flip, w0, w1, 4, 0, 0);
    end

    // reset in the middle of a held write
    bp = bp ^ 2'b10;
    bypass_req = bp;
    for (int k = 1; k <= 6; k++) begin
      @(posedge sys_clk);
      #1 avs_waitrequest = 2'b10;
      @(negedge sys_clk);
    end
    chk("mid_write", 64'(avs_write), 64'(2'b10));
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_write", 64'(avs_write), 64'(0));
    chk("mid_rst_shadow", 64'(cfg_shadow), 64'(0));
    chk("mid_rst_err", 64'(err), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(1));
    avs_waitrequest = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    m_shadow = '0;
    m_err = '0;
    run_seq(2'b11, $urandom_range(0, 6), $urandom_range(0, 6), 4, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_cfg_sequencer.md
# video_cfg_sequencer

Configuration sequencer for the video daisy-chain cores' bypass control registers. It synchronizes and debounces board inputs (bypass switches, one push-button), tracks pending per-core updates, and issues Avalon-MM writes to each core one at a time with a waitrequest handshake. It replaces the ad-hoc switch/key write logic between the board top and the daisy-chain cores in the `sys_clk` domain.

## Interface
- `NUM_CORE`, 2, number of daisy-chain cores controlled (index 0 = bar core, 1 = rgb2gray core)
- `DEBOUNCE_CYCLES`, 500000, cycles the synchronized key must be stable before a change is accepted (10 ms at 50 MHz)
- `TIMEOUT_CYCLES`, 1024, maximum cycles a write may be held by waitrequest before abort
- `sys_clk`  in  1  system clock
- `sys_rst_n`  in  1  asynchronous active-low reset
- `bypass_req`  in  NUM_CORE  requested bypass per core, asynchronous (switches)
- `key_n`  in  1  update push-button, active-low, asynchronous
- `auto_mode`  in  1  1 = write on any bypass_req change; 0 = write only on key press (quasi-static, synchronized with bypass_req)
- `avs_address`  out  NUM_CORE  per-core address, always 0
- `avs_write`  out  NUM_CORE  per-core write strobe, at most one bit set
- `avs_writedata`  out  32*NUM_CORE  per-core write data, slice i = {31'b0, value}
- `avs_waitrequest`  in  NUM_CORE  per-core waitrequest
- `cfg_shadow`  out  NUM_CORE  last value successfully written per core
- `busy`  out  1  state != IDLE or pending != 0
- `done`  out  1  one-cycle pulse when a write sequence finishes with nothing pending
- `err`  out  NUM_CORE  sticky per-core timeout flag

## Operation
- Clock and reset: one clock (`sys_clk`); reset (`sys_rst_n`) is asynchronous and active-low.
- Input sync: `bypass_req`, `key_n`, `auto_mode` each pass through 2 flops. Debounce: a counter reloads on any change of synchronized key; the debounced key updates when the counter reaches DEBOUNCE_CYCLES-1. A press event is a debounced 1->0 transition.
- Pending register `pend[NUM_CORE]`:
  - set all ones on a press event
  - set bit i when `auto_mode` and `bypass_sync[i] != cfg_shadow[i]`; bit of the core in WRITE/NEXT is masked from this compare
  - cleared for the current core in NEXT
  - set has priority over clear in the same cycle
- FSM:
  - WARMUP: 3 cycles after reset, then IDLE.
  - IDLE: if pend != 0, latch `cur` = lowest set index and `wdata` = bypass_sync[cur], go WRITE.
  - WRITE: `avs_write[cur]`=1, address 0, writedata slice = {31'b0, wdata}, all held stable.
    - waitrequest[cur]=0 in this cycle: transaction accepted, go NEXT with ok=1.
    - otherwise the timeout counter increments; at TIMEOUT_CYCLES-1 go NEXT with ok=0.
  - NEXT: clear pend[cur].
    - ok=1: cfg_shadow[cur]<=wdata, err[cur]<=0.
    - ok=0: err[cur]<=1, shadow unchanged.
    - Then go IDLE. `done` pulses in the IDLE cycle following NEXT if pend==0 there.
- Reset values: all outputs 0 (`avs_write`=0, `cfg_shadow`=0, `err`=0, `done`=0). `pend` resets to all ones, so every core is written once after WARMUP. Debounced key resets to 1. State resets to WARMUP. `busy`=1 during reset release because pend != 0.
- A timed-out core in auto mode is re-pended by the mismatch compare: retries continue, with `err` set until a success.

## Timing
- Per-core write with no waitrequest: 3 cycles (IDLE, WRITE, NEXT).
- First `avs_write` after reset release: cycle 4 (3 WARMUP cycles + IDLE).
- Key press to `avs_write`: 2 sync + DEBOUNCE_CYCLES + 1 event + 1 IDLE cycles.
- Auto-mode switch change to `avs_write`: 2 sync + 1 pend + 1 IDLE = 4 cycles when idle.
- Sequence over n cores: 3n cycles, plus wait cycles, to `done`.
- Reset mid-write: `avs_write` drops asynchronously; after release, all cores are rewritten.
- Press during a sequence: all bits re-pend, and the sequence continues without `done` in between.

## Test plan
- Reset, bypass_req=2'b10, waitrequest=0 -> writes core0 data 0 then core1 data 1 at cycles 4 and 7, `done` at cycle 9, cfg_shadow=2'b10.
- auto_mode=1, flip bypass_req[0] 0->1 when idle -> a single write to core0 with data 1 exactly 4 cycles later; core1 not written.
- auto_mode=0, key glitches shorter than DEBOUNCE_CYCLES -> no write. Held low longer -> both cores written once.
- waitrequest[1] high for 5 cycles -> avs_write[1] and data held 6 cycles; shadow updates after release.
- waitrequest[0] stuck high, TIMEOUT_CYCLES=16 -> write dropped after 16 cycles; err[0]=1; core1 still written. Release waitrequest -> retry clears err[0].
- Assert sys_rst_n mid-WRITE -> avs_write=0 immediately, outputs at reset values. Full rewrite follows release.
